// File: rtl/alu_issue.sv
// alu_issue: decode-and-issue stage feeding the ALU.
// Decodes RV32I OP / OP-IMM / LUI / AUIPC on the input side and stores the
// decoded bundle in a 2-entry skid buffer. Slot 0 is always the head, so every
// bundle output comes straight from a flop.
module alu_issue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] opa,
  output logic [XLEN-1:0] opb,
  output logic [3:0]      alu_op,
  output logic [4:0]      rd,
  output logic            rd_we,
  output logic            illegal
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  // Bundle layout: {opa, opb, alu_op, rd, rd_we, illegal}
  localparam int BW = 2 * XLEN + 4 + 5 + 1 + 1;
  localparam logic [BW-1:0] BUNDLE_RST = '0;  // ADD encodes as 0
  localparam logic [1:0] CNT_FULL = DEPTH[1:0];

  logic [1:0]    count_q, count_d;
  logic [BW-1:0] slot0_q, slot0_d;
  logic [BW-1:0] slot1_q, slot1_d;
  logic [BW-1:0] dec_s;
  logic          push_s, pop_s;

  logic [6:0]      opc_s, f7_s;
  logic [2:0]      f3_s;
  logic [3:0]      dop_s;
  logic [XLEN-1:0] da_s, db_s;
  logic            dill_s, dwe_s;
  logic            unused_instr_s;

  assign opc_s = instr[6:0];
  assign f3_s  = instr[14:12];
  assign f7_s  = instr[31:25];
  // rs1/rs2 index fields arrive already resolved as rs1_data/rs2_data.
  assign unused_instr_s = ^instr[19:15];

  // Decode the incoming instruction into the ALU bundle.
  always_comb begin
    dop_s  = ALU_ADD;
    da_s   = '0;
    db_s   = '0;
    dill_s = 1'b0;
    case (opc_s)
      OPC_OP, OPC_OPIMM: begin
        da_s = rs1_data;
        if (opc_s == OPC_OP) begin
          db_s = rs2_data;
        end else if (f3_s == 3'b001 || f3_s == 3'b101) begin
          db_s = {27'b0, instr[24:20]};
        end else begin
          db_s = {{20{instr[31]}}, instr[31:20]};
        end
        case (f3_s)
          3'b000: begin
            if (opc_s == OPC_OPIMM || f7_s == F7_ZERO) dop_s = ALU_ADD;
            else if (f7_s == F7_ALT) dop_s = ALU_SUB;
            else dill_s = 1'b1;
          end
          3'b001: begin
            if (f7_s == F7_ZERO) dop_s = ALU_SLL;
            else dill_s = 1'b1;
          end
          3'b101: begin
            if (f7_s == F7_ZERO) dop_s = ALU_SRL;
            else if (f7_s == F7_ALT) dop_s = ALU_SRA;
            else dill_s = 1'b1;
          end
          3'b010, 3'b011, 3'b100, 3'b110, 3'b111: begin
            case (f3_s)
              3'b010:  dop_s = ALU_SLT;
              3'b011:  dop_s = ALU_SLTU;
              3'b100:  dop_s = ALU_XOR;
              3'b110:  dop_s = ALU_OR;
              default: dop_s = ALU_AND;
            endcase
            // Immediate forms have no funct7 field to police.
            if (opc_s == OPC_OP && f7_s != F7_ZERO) dill_s = 1'b1;
            else dill_s = 1'b0;
          end
          default: dill_s = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dop_s = ALU_PASS;
        db_s  = {instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        dop_s = ALU_ADD;
        da_s  = pc;
        db_s  = {instr[31:12], 12'b0};
      end
      default: dill_s = 1'b1;
    endcase
    // Illegal encodings still issue, but as a harmless ADD 0,0 with no write-back.
    if (dill_s) begin
      dop_s = ALU_ADD;
      da_s  = '0;
      db_s  = '0;
    end else begin
      dop_s = dop_s;
    end
    dwe_s = !dill_s && (instr[11:7] != 5'd0);
  end

  assign dec_s = {da_s, db_s, dop_s, instr[11:7], dwe_s, dill_s};

  assign in_ready  = (count_q != CNT_FULL);
  assign out_valid = (count_q != 2'd0);
  assign push_s    = in_valid && in_ready && !flush;
  assign pop_s     = out_valid && out_ready && !flush;

  // Skid buffer next state: slot 0 is the head, slot 1 the tail when full.
  always_comb begin
    count_d = count_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push_s) begin
            slot0_d = dec_s;
            count_d = 2'd1;
          end else begin
            count_d = 2'd0;
          end
        end
        2'd1: begin
          if (push_s && pop_s) begin
            slot0_d = dec_s;
          end else if (push_s) begin
            slot1_d = dec_s;
            count_d = 2'd2;
          end else if (pop_s) begin
            count_d = 2'd0;
          end else begin
            count_d = 2'd1;
          end
        end
        2'd2: begin
          if (pop_s) begin
            slot0_d = slot1_q;
            count_d = 2'd1;
          end else begin
            count_d = 2'd2;
          end
        end
        default: count_d = 2'd0;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      slot0_q <= BUNDLE_RST;
      slot1_q <= BUNDLE_RST;
    end else begin
      count_q <= count_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  assign opa     = slot0_q[BW-1 -: XLEN];
  assign opb     = slot0_q[BW-1-XLEN -: XLEN];
  assign alu_op  = slot0_q[10:7];
  assign rd      = slot0_q[6:2];
  assign rd_we   = slot0_q[1];
  assign illegal = slot0_q[0];

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue.
module tb_alu_issue;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, XOR = 4'd2, OR = 4'd3, AND = 4'd4;
  localparam logic [3:0] SLL = 4'd5, SRL = 4'd6, SRA = 4'd7, SLT = 4'd8, SLTU = 4'd9, PASS = 4'd10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = 32'h0;
  logic [31:0] pc = 32'h0;
  logic [31:0] rs1_data = 32'h0;
  logic [31:0] rs2_data = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] opa, opb;
  logic [3:0]  alu_op;
  logic [4:0]  rd;
  logic        rd_we, illegal;

  int total = 0;
  int bad = 0;

  alu_issue dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .opa(opa), .opb(opb),
    .alu_op(alu_op), .rd(rd), .rd_we(rd_we), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // {out_valid, in_ready, opa, opb, alu_op, rd, rd_we, illegal}
  logic [76:0] obs;
  assign obs = {out_valid, in_ready, opa, opb, alu_op, rd, rd_we, illegal};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p);
    instr = i; rs1_data = a; rs2_data = b; pc = p; in_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; instr = 32'h002081B3; rs1_data = 32'h55;
    tick(); tick();
    total++;
    if (obs !== {1'b0, 1'b1, 32'h0, 32'h0, ADD, 5'd0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset: got %h want %h", obs, {1'b0, 1'b1, 72'h0, 3'b0});
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_decode();
    logic [31:0] vi [13];
    logic [31:0] va [13];
    logic [31:0] vp [13];
    logic [76:0] ve [13];
    vi = '{32'h002081B3, 32'h402081B3, 32'hFFF00293, 32'h40415093, 32'h123450B7,
           32'h00001197, 32'h00000073, 32'h022081B3, 32'h00208033, 32'h0020F1B3,
           32'h40209193, 32'h4020C1B3, 32'hFFF0B193};
    va = '{32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5,
           32'd5, 32'd5, 32'd5};
    vp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h100, 32'h0, 32'h0, 32'h0, 32'h0,
           32'h0, 32'h0, 32'h0};
    ve = '{{2'b11, 32'd5, 32'd7, ADD, 5'd3, 1'b1, 1'b0},
           {2'b11, 32'd5, 32'd7, SUB, 5'd3, 1'b1, 1'b0},
           {2'b11, 32'd5, 32'hFFFFFFFF, ADD, 5'd5, 1'b1, 1'b0},
           {2'b11, 32'd5, 32'h00000004, SRA, 5'd1, 1'b1, 1'b0},
           {2'b11, 32'd0, 32'h12345000, PASS, 5'd1, 1'b1, 1'b0},
           {2'b11, 32'h100, 32'h00001000, ADD, 5'd3, 1'b1, 1'b0},
           {2'b11, 32'd0, 32'd0, ADD, 5'd0, 1'b0, 1'b1},
           {2'b11, 32'd0, 32'd0, ADD, 5'd3, 1'b0, 1'b1},
           {2'b11, 32'd5, 32'd7, ADD, 5'd0, 1'b0, 1'b0},
           {2'b11, 32'd5, 32'd7, AND, 5'd3, 1'b1, 1'b0},
           {2'b11, 32'd0, 32'd0, ADD, 5'd3, 1'b0, 1'b1},
           {2'b11, 32'd0, 32'd0, ADD, 5'd3, 1'b0, 1'b1},
           {2'b11, 32'd5, 32'hFFFFFFFF, SLTU, 5'd3, 1'b1, 1'b0}};
    out_ready = 1'b1;
    for (int k = 0; k < 13; k++) begin
      drive(vi[k], va[k], 32'd7, vp[k]);
      tick();
      in_valid = 1'b0;
      total++;
      if (obs !== ve[k]) begin
        bad++; $display("FAIL decode[%0d] instr=%h: got %h want %h", k, vi[k], obs, ve[k]);
      end
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL decode_drain: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(32'h002081B3, 32'd11, 32'd0, 32'h0);
    tick();
    total++;
    if ({out_valid, in_ready, opa} !== {2'b11, 32'd11}) begin
      bad++; $display("FAIL bp_first: got %b%b %0d want 11 11", out_valid, in_ready, opa);
    end
    drive(32'h002081B3, 32'd22, 32'd0, 32'h0);
    tick();
    total++;
    if ({out_valid, in_ready, opa} !== {2'b10, 32'd11}) begin
      bad++; $display("FAIL bp_full: got %b%b %0d want 10 11", out_valid, in_ready, opa);
    end
    drive(32'h002081B3, 32'd33, 32'd0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if ({out_valid, in_ready, opa, alu_op, rd} !== {2'b10, 32'd11, ADD, 5'd3}) begin
        bad++; $display("FAIL bp_hold[%0d]: got %b%b %0d want 10 11", k, out_valid, in_ready, opa);
      end
    end
    out_ready = 1'b1;
    tick();
    total++;
    if ({out_valid, in_ready, opa} !== {2'b11, 32'd22}) begin
      bad++; $display("FAIL bp_pop1: got %b%b %0d want 11 22", out_valid, in_ready, opa);
    end
    tick();
    in_valid = 1'b0;
    total++;
    if ({out_valid, opa} !== {1'b1, 32'd33}) begin
      bad++; $display("FAIL bp_pop2: got %b %0d want 1 33", out_valid, opa);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_nodup: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(32'h002081B3, 32'd1, 32'd0, 32'h0);
    tick();
    drive(32'h002081B3, 32'd2, 32'd0, 32'h0);
    tick();
    drive(32'h002081B3, 32'd3, 32'd0, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++; $display("FAIL flush: got valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL flush_gone: out_valid got %b want 0", out_valid);
    end
    drive(32'h402081B3, 32'd4, 32'd1, 32'h0);
    tick();
    in_valid = 1'b0;
    total++;
    if ({out_valid, opa, opb, alu_op} !== {1'b1, 32'd4, 32'd1, SUB}) begin
      bad++; $display("FAIL flush_after: got %b %0d %0d %0d want 1 4 1 1", out_valid, opa, opb, alu_op);
    end
    tick();
  endtask

  task automatic test_rst_midstream();
    out_ready = 1'b0;
    drive(32'h402081B3, 32'd9, 32'd8, 32'h0);
    tick();
    drive(32'h123450B7, 32'd9, 32'd8, 32'h0);
    tick();
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL rst_fill: in_ready got %b want 0", in_ready);
    end
    rst = 1'b1;
    flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    total++;
    if (obs !== {1'b0, 1'b1, 32'h0, 32'h0, ADD, 5'd0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL rst_mid: got %h want %h", obs, {1'b0, 1'b1, 75'h0});
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_mid_after: out_valid got %b want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_backpressure();
    test_flush();
    test_rst_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
